bpsk_tx_scheduler: RTL and testbench

Transmit controller for the BPSK modulator chain: phase counter, sine generator and bit sender. Arbitrates round-robin between two packet sources and frames each accepted packet as preamble, sync word, then payload. Presents one bit at a time to the phase counter, advancing only on the counter's next-bit strobe. Gates the carrier (tx_active) so the modulator is silent between frames.

---
 rtl/bpsk_tx_scheduler.sv | 171 +++++++++++++++++
 tb/tb_bpsk_tx_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_tx_scheduler.sv
// bpsk_tx_scheduler: round-robin arbiter and bit framer for the BPSK modulator.
// Each accepted packet goes out as an alternating preamble, the sync word, then
// the payload MSB first, followed by a silent gap with the carrier gated off.
module bpsk_tx_scheduler #(
  parameter int         PACKET_SIZE   = 184,
  parameter int         PREAMBLE_BITS = 16,
  parameter logic [7:0] SYNC_WORD     = 8'hD3,
  parameter int         GAP_BITS      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   bit_strobe,
  input  logic                   req0,
  input  logic [PACKET_SIZE-1:0] data0,
  input  logic                   req1,
  input  logic [PACKET_SIZE-1:0] data1,
  output logic                   grant0,
  output logic                   grant1,
  output logic                   tx_bit,
  output logic                   tx_active,
  output logic                   busy,
  output logic                   done,
  output logic                   src
);

  localparam int MAX_A = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int MAX_B = (PACKET_SIZE > GAP_BITS) ? PACKET_SIZE : GAP_BITS;
  localparam int MAX_N = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_N + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PACKET_SIZE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_PAYLOAD,
    S_GAP
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [PACKET_SIZE-1:0] shift_q;
  logic                   last_q;
  logic                   grant0_q, grant1_q, done_q, src_q;
  logic                   tx_bit_q, tx_active_q, busy_q;

  logic                   win_d;
  logic                   any_req_d;
  logic [2:0]             sync_idx_d;
  logic                   load_d;
  logic                   shift_d;

  // Arbitration and datapath enables derived from the current state
  always_comb begin
    any_req_d  = req0 | req1;
    win_d      = (req0 && req1) ? ~last_q : req1;
    sync_idx_d = 3'd6 - cnt_q[2:0];
    load_d     = (state_q == S_IDLE) && any_req_d;
    shift_d    = (state_q == S_PAYLOAD) && bit_strobe;
  end

  // Payload shift register: captured at grant, shifted left once per payload bit
  always_ff @(posedge clock) begin
    if (load_d) begin
      shift_q <= win_d ? data1 : data0;
    end else if (shift_d) begin
      shift_q <= {shift_q[PACKET_SIZE-2:0], 1'b0};
    end
  end

  // Frame sequencer with registered outputs; bits advance only on bit_strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      grant0_q    <= 1'b0;
      grant1_q    <= 1'b0;
      done_q      <= 1'b0;
      src_q       <= 1'b0;
      tx_bit_q    <= 1'b0;
      tx_active_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            src_q       <= win_d;
            last_q      <= win_d;
            grant0_q    <= ~win_d;
            grant1_q    <= win_d;
            tx_bit_q    <= 1'b1;
            tx_active_q <= 1'b1;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_PREAMBLE;
          end
        end
        S_PREAMBLE: begin
          if (bit_strobe) begin
            if (cnt_q == PRE_LAST) begin
              tx_bit_q <= SYNC_WORD[7];
              cnt_q    <= '0;
              state_q  <= S_SYNC;
            end else begin
              // next bit index is cnt+1: even indices carry 1
              tx_bit_q <= cnt_q[0];
              cnt_q    <= cnt_q + 1'b1;
            end
          end
        end
        S_SYNC: begin
          if (bit_strobe) begin
            if (cnt_q == SYNC_LAST) begin
              tx_bit_q <= shift_q[PACKET_SIZE-1];
              cnt_q    <= '0;
              state_q  <= S_PAYLOAD;
            end else begin
              tx_bit_q <= SYNC_WORD[sync_idx_d];
              cnt_q    <= cnt_q + 1'b1;
            end
          end
        end
        S_PAYLOAD: begin
          if (bit_strobe) begin
            if (cnt_q == PAY_LAST) begin
              tx_bit_q    <= 1'b0;
              tx_active_q <= 1'b0;
              cnt_q       <= '0;
              state_q     <= S_GAP;
            end else begin
              tx_bit_q <= shift_q[PACKET_SIZE-2];
              cnt_q    <= cnt_q + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (bit_strobe) begin
            if (cnt_q == GAP_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant0    = grant0_q;
  assign grant1    = grant1_q;
  assign tx_bit    = tx_bit_q;
  assign tx_active = tx_active_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign src       = src_q;

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Testbench for bpsk_tx_scheduler: directed scenarios with random payloads,
// checked against a frame model built as {preamble, sync, payload} bit strings.
module tb_bpsk_tx_scheduler;

  localparam int         PS   = 16;
  localparam int         PB   = 4;
  localparam int         GB   = 2;
  localparam logic [7:0] SW   = 8'hD3;
  localparam int         NACT = PB + 8 + PS;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          bit_strobe = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [PS-1:0] data0 = '0;
  logic [PS-1:0] data1 = '0;
  logic          grant0, grant1, tx_bit, tx_active, busy, done, src;

  int   checks = 0;
  int   errors = 0;
  logic last_m = 1'b1;
  logic order_src;

  bpsk_tx_scheduler #(
    .PACKET_SIZE  (PS),
    .PREAMBLE_BITS(PB),
    .SYNC_WORD    (SW),
    .GAP_BITS     (GB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bit_strobe(bit_strobe),
    .req0      (req0),
    .data0     (data0),
    .req1      (req1),
    .data1     (data1),
    .grant0    (grant0),
    .grant1    (grant1),
    .tx_bit    (tx_bit),
    .tx_active (tx_active),
    .busy      (busy),
    .done      (done),
    .src       (src)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive strobe for this edge, then sample 1ns after it
  task automatic step(input logic s);
    bit_strobe = s;
    @(posedge clock);
    #1;
    bit_strobe = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx_active"}, tx_active, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_tx_bit"}, tx_bit, 1'b0);
    chk({tag, "_grant0"}, grant0, 1'b0);
    chk({tag, "_grant1"}, grant1, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  function automatic logic pick(input logic r0, input logic r1);
    return (r0 && r1) ? ~last_m : r1;
  endfunction

  // Runs one frame from an IDLE edge with a request pending. The expected frame
  // is the concatenated bit string; each period is 4 clocks unless fast0 makes
  // the grant cycle itself carry the first strobe.
  task automatic run_frame(input logic drop, input logic fast0, input logic disturb,
                           input int abort_at);
    logic            esrc;
    logic [PS-1:0]   d;
    logic [PB-1:0]   pre;
    logic [NACT-1:0] fr;
    logic            eb;
    int              jmax;
    esrc = pick(req0, req1);
    d    = esrc ? data1 : data0;
    for (int i = 0; i < PB; i++) pre[PB-1-i] = (i % 2 == 0);
    fr = {pre, SW, d};
    step(1'b0);
    last_m = esrc;
    chk("grant0", grant0, ~esrc);
    chk("grant1", grant1, esrc);
    chk("grant_src", src, esrc);
    chk("grant_busy", busy, 1'b1);
    if (drop) begin
      if (esrc) req1 = 1'b0;
      else      req0 = 1'b0;
    end
    for (int k = 0; k < NACT + GB; k++) begin
      if (k == abort_at) return;
      jmax = (k == 0 && fast0) ? 0 : 3;
      for (int j = 0; j <= jmax; j++) begin
        eb = (k < NACT) ? fr[NACT-1-k] : 1'b0;
        chk("tx_bit", tx_bit, eb);
        chk("tx_active", tx_active, (k < NACT));
        chk("busy", busy, 1'b1);
        chk("done_early", done, 1'b0);
        if (!(k == 0 && j == 0)) chk("grant_while_busy", grant0 | grant1, 1'b0);
        if (disturb && k == 14 && j == 1) begin
          req1  = 1'b1;
          data0 = PS'($urandom);
        end
        if (disturb && k == 14 && j == 2) req1 = 1'b0;
        step(j == jmax);
      end
    end
    chk("done", done, 1'b1);
    chk("end_busy", busy, 1'b0);
    chk("end_tx_active", tx_active, 1'b0);
    chk("end_tx_bit", tx_bit, 1'b0);
    chk("end_src", src, esrc);
  endtask

  initial begin
    // Reset state, with a strobe arriving during reset
    reset = 1'b1;
    step(1'b1);
    step(1'b0);
    chk_idle("reset");
    chk("reset_src", src, 1'b0);
    reset  = 1'b0;
    last_m = 1'b1;

    // Strobe in IDLE with no request changes nothing
    step(1'b1);
    chk_idle("idle_strobe");
    step(1'b0);
    chk_idle("idle_quiet");

    // Single request with the reference payload
    data0 = 16'hA55A;
    req0  = 1'b1;
    run_frame(1'b1, 1'b0, 1'b0, -1);
    step(1'b0);
    chk_idle("after_single");
    chk("single_src_hold", src, 1'b0);

    // Contention after reset: source 0 first, then source 1 right after done
    reset = 1'b1;
    step(1'b0);
    reset  = 1'b0;
    last_m = 1'b1;
    data0  = PS'($urandom);
    data1  = PS'($urandom);
    req0   = 1'b1;
    req1   = 1'b1;
    run_frame(1'b1, 1'b0, 1'b0, -1);
    chk("contend_first_src", src, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, -1);
    chk("contend_second_src", src, 1'b1);
    step(1'b0);
    chk_idle("after_contend");

    // Fairness: both requesting for four frames alternates 0,1,0,1
    reset = 1'b1;
    step(1'b0);
    reset  = 1'b0;
    last_m = 1'b1;
    req0   = 1'b1;
    req1   = 1'b1;
    for (int f = 0; f < 4; f++) begin
      data0 = PS'($urandom);
      data1 = PS'($urandom);
      run_frame(1'b0, 1'b0, 1'b0, -1);
      order_src = src;
      chk("fair_order", order_src, (f % 2 == 1));
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step(1'b0);
    chk_idle("after_fair");

    // Reset at payload bit 5, then held req1 is granted right after reset falls
    reset = 1'b1;
    step(1'b0);
    reset  = 1'b0;
    last_m = 1'b1;
    data0  = PS'($urandom);
    data1  = PS'($urandom);
    req0   = 1'b1;
    req1   = 1'b1;
    run_frame(1'b1, 1'b0, 1'b0, PB + 8 + 5);
    reset = 1'b1;
    step(1'b1);
    chk_idle("abort");
    reset  = 1'b0;
    last_m = 1'b1;
    run_frame(1'b1, 1'b0, 1'b0, -1);
    chk("abort_regrant_src", src, 1'b1);
    step(1'b0);
    chk_idle("after_abort");

    // Strobe coinciding with the grant cycle shortens preamble bit 0
    data0 = PS'($urandom);
    req0  = 1'b1;
    run_frame(1'b1, 1'b1, 1'b0, -1);
    step(1'b0);
    chk_idle("after_fast");

    // req1 pulsed and data0 changed mid-frame: ignored
    data0 = PS'($urandom);
    req0  = 1'b1;
    run_frame(1'b1, 1'b0, 1'b1, -1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk_idle("after_disturb");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
